seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match-counter width, legal range 1..32.
REQ-003 SHALL have parameter RST_PAT, default {PAT_W{1'b0}}: pattern-register value after reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstb  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port clr  input  1  synchronous clear of detection state.
REQ-007 SHALL have port pat_load  input  1  capture pattern into the pattern register.
REQ-008 SHALL have port pattern  input  PAT_W  new pattern; MSB is the oldest bit of the sequence.
REQ-009 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port en  input  1  x_in is a valid sample this cycle.
REQ-011 SHALL have port x_in  input  1  serial data bit.
REQ-012 SHALL have port shift_reg  output  PAT_W  last PAT_W accepted bits, newest in LSB.
REQ-013 SHALL have port y_out  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 Per-edge priority SHALL be clr > pat_load > en sample; the lower-priority action is dropped that cycle.
REQ-016 clr=1 SHALL set shift_reg, fill count, y_out and match_cnt to 0 and SHALL retain the pattern register.
REQ-017 pat_load=1 (clr=0) SHALL load pattern into the pattern register and set shift_reg, fill count and y_out to 0; match_cnt SHALL be retained.
REQ-018 An accepted sample (en=1, clr=0, pat_load=0) SHALL compute nxt_shift = {shift_reg[PAT_W-2:0], x_in} and nxt_fill = min(fill+1, PAT_W).
REQ-019 The sample SHALL be a match iff nxt_fill == PAT_W and nxt_shift == pattern register.
REQ-020 y_out SHALL equal 1 in the cycle after a matching sample and 0 otherwise; latency is one clock from the sampling edge.
REQ-021 With en=0 (and no clr or pat_load), shift_reg and fill SHALL hold and y_out SHALL be 0.
REQ-022 On a match with overlap=1, shift_reg SHALL take nxt_shift and fill SHALL stay PAT_W, so back-to-back matches are possible every sample.
REQ-023 On a match with overlap=0, shift_reg SHALL take nxt_shift and fill SHALL reset to 0, so the next match needs PAT_W further accepted samples.
REQ-024 Each match SHALL increment match_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 overlap SHALL be sampled on the same edge as the sample it affects; changing it mid-stream SHALL not alter fill or shift_reg.
REQ-026 The fill counter SHALL be $clog2(PAT_W+1) bits wide and SHALL never exceed PAT_W.

Reset
REQ-027 rstb=0 SHALL asynchronously force shift_reg=0, fill=0, y_out=0, match_cnt=0 and the pattern register to RST_PAT.
REQ-028 After rstb deasserts, the first edge SHALL behave as a normal cycle; reset mid-stream SHALL discard partial sequences.

Structure
REQ-029 Package seq_det_pkg SHALL hold the PAT_W/CNT_W default constants and the fill-width function.
REQ-030 The saturating counter SHALL be sub-module sat_counter (parameter W; inputs clk, rstb, clr, inc; output q).
REQ-031 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from input to output.

Verification (PAT_W=4, pattern 4'b1011 loaded after reset unless stated)
REQ-032 overlap=1, stream 1,0,1,1,0,1,1 -> y_out pulses after the 4th and 7th samples, match_cnt=2.
REQ-033 overlap=0, same stream -> a single pulse after the 4th sample, none after the 7th (fill=3), match_cnt=1.
REQ-034 Stream 1,0,[en=0 x3],1,1 -> y_out=0 during the gap, a pulse after the final sample, shift_reg=4'b1011.
REQ-035 Pattern 4'b0000, overlap=1, zeros from reset -> no pulse for samples 1-3, then a pulse every sample from the 4th.
REQ-036 CNT_W=2, five overlapping matches -> match_cnt reaches 3 and holds; a clr in the same cycle as a match leaves match_cnt=0 and y_out=0.
REQ-037 rstb low after samples 1,0,1, then sample 1 -> all outputs 0 during reset, no pulse afterwards, pattern register=RST_PAT.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and width helper for the serial pattern detector
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // The fill counter has to represent 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear, holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised serial pattern detector with overlap control
// and a saturating match counter; every output comes straight from a flop.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] RST_PAT = {PAT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             en,
  input  logic             x_in,
  output logic [PAT_W-1:0] shift_reg,
  output logic             y_out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  nxt_shift;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] nxt_fill;
  logic              accept;
  logic              hit;

  // clr beats pat_load beats the sample, so a sample only counts when both are low.
  always_comb begin
    accept    = en & ~clr & ~pat_load;
    nxt_shift = {shift_reg[PAT_W-2:0], x_in};
    nxt_fill  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    hit       = accept && (nxt_fill == FILL_FULL) && (nxt_shift == pat_q);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pat_q <= RST_PAT;
    end else if (!clr && pat_load) begin
      pat_q <= pattern;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shift_reg <= '0;
      fill_q    <= '0;
      y_out     <= 1'b0;
    end else if (clr || pat_load) begin
      shift_reg <= '0;
      fill_q    <= '0;
      y_out     <= 1'b0;
    end else if (en) begin
      shift_reg <= nxt_shift;
      // Non-overlapping mode restarts the fill so the next match needs fresh bits.
      fill_q    <= (hit && !overlap) ? '0 : nxt_fill;
      y_out     <= hit;
    end else begin
      y_out     <= 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rstb(rstb),
    .clr (clr),
    .inc (hit),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - two detector instances (8-bit and 2-bit counters, different
// reset patterns) driven in parallel and checked against a bit-history model every cycle.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb = 1'b0;
  logic       clr, pat_load, overlap, en, x_in;
  logic [3:0] pattern;
  logic [3:0] sh_a, sh_b;
  logic       y_a, y_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  localparam logic [3:0] RST_A = 4'b0000;
  localparam logic [3:0] RST_B = 4'b0110;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rstb(rstb), .clr(clr), .pat_load(pat_load), .pattern(pattern),
    .overlap(overlap), .en(en), .x_in(x_in),
    .shift_reg(sh_a), .y_out(y_a), .match_cnt(cnt_a)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(RST_B)) dut_b (
    .clk(clk), .rstb(rstb), .clr(clr), .pat_load(pat_load), .pattern(pattern),
    .overlap(overlap), .en(en), .x_in(x_in),
    .shift_reg(sh_b), .y_out(y_b), .match_cnt(cnt_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_max(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  // Model: m_since counts accepted bits since the last restart point; the window is the
  // last four accepted bits as a number.
  logic [3:0] m_pat   [2];
  logic [3:0] m_shift [2];
  int         m_since [2];
  int         m_cnt   [2];
  logic       m_y     [2];

  always @(posedge clk or negedge rstb) begin
    logic [3:0] sh;
    int         s;
    logic       hit;
    for (int k = 0; k < 2; k++) begin
      if (!rstb) begin
        m_pat[k]   <= (k == 0) ? RST_A : RST_B;
        m_shift[k] <= 4'b0;
        m_since[k] <= 0;
        m_y[k]     <= 1'b0;
        m_cnt[k]   <= 0;
      end else if (clr) begin
        m_shift[k] <= 4'b0;
        m_since[k] <= 0;
        m_y[k]     <= 1'b0;
        m_cnt[k]   <= 0;
      end else if (pat_load) begin
        m_pat[k]   <= pattern;
        m_shift[k] <= 4'b0;
        m_since[k] <= 0;
        m_y[k]     <= 1'b0;
      end else if (en) begin
        sh  = 4'((int'(m_shift[k]) * 2 + int'(x_in)) % 16);
        s   = m_since[k] + 1;
        hit = (s >= 4) && (sh == m_pat[k]);
        m_shift[k] <= sh;
        m_since[k] <= (hit && !overlap) ? 0 : s;
        m_y[k]     <= hit;
        if (hit && (m_cnt[k] < cnt_max(k))) m_cnt[k] <= m_cnt[k] + 1;
      end else begin
        m_y[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("y_a",     int'(y_a),   int'(m_y[0]));
      check("shift_a", int'(sh_a),  int'(m_shift[0]));
      check("cnt_a",   int'(cnt_a), m_cnt[0]);
      check("y_b",     int'(y_b),   int'(m_y[1]));
      check("shift_b", int'(sh_b),  int'(m_shift[1]));
      check("cnt_b",   int'(cnt_b), m_cnt[1]);
    end
  end

  task automatic cyc(input logic r, input logic c, input logic l, input logic [3:0] p,
                     input logic o, input logic e, input logic x);
    rstb = r; clr = c; pat_load = l; pattern = p; overlap = o; en = e; x_in = x;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic samp(input logic o, input logic x);
    cyc(1'b1, 1'b0, 1'b0, 4'b0, o, 1'b1, x);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] p);
    cyc(1'b1, 1'b0, 1'b1, p, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clr();
    cyc(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    cyc(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ys collects y_a per sample, first sample in the MSB position of the n-bit field.
  task automatic run_stream(input logic o, input logic [15:0] bits_in, input int n,
                            output logic [15:0] ys);
    ys = 16'b0;
    for (int i = 0; i < n; i++) begin
      samp(o, bits_in[n-1-i]);
      ys[n-1-i] = y_a;
    end
  endtask

  initial begin
    logic [15:0] ys;
    logic [3:0]  rp;
    int          r;
    clr = 1'b0; pat_load = 1'b0; pattern = 4'b0; overlap = 1'b0; en = 1'b0; x_in = 1'b0;
    rstb = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_y",     int'(y_a),   0);
    check("rst_shift", int'(sh_a),  0);
    check("rst_cnt",   int'(cnt_a), 0);

    load(4'b1011);
    run_stream(1'b1, 16'b1011011, 7, ys);
    check("ovl_pulses", int'(ys), 7'b0001001);
    check("ovl_cnt",    int'(cnt_a), 2);

    do_clr();
    run_stream(1'b0, 16'b1011011, 7, ys);
    check("novl_pulses", int'(ys), 7'b0001000);
    check("novl_cnt",    int'(cnt_a), 1);
    check("novl_shift",  int'(sh_a), 4'b1011);

    do_clr();
    samp(1'b1, 1'b1);
    samp(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("gap_y", int'(y_a), 0);
    end
    samp(1'b1, 1'b1);
    check("gap_pre_y", int'(y_a), 0);
    samp(1'b1, 1'b1);
    check("gap_final_y",     int'(y_a),  1);
    check("gap_final_shift", int'(sh_a), 4'b1011);

    do_rst();
    load(4'b0000);
    run_stream(1'b1, 16'b0, 8, ys);
    check("zero_pulses", int'(ys), 8'b00011111);
    check("zero_cnt_a",  int'(cnt_a), 5);
    check("zero_cnt_b",  int'(cnt_b), 3);
    cyc(1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b1, 1'b0);
    check("clr_hit_y",   int'(y_a),   0);
    check("clr_hit_cnt", int'(cnt_a), 0);

    load(4'b1011);
    samp(1'b1, 1'b1);
    samp(1'b1, 1'b0);
    samp(1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1);
    check("mid_rst_y",     int'(y_a),   0);
    check("mid_rst_shift", int'(sh_a),  0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1);
    samp(1'b1, 1'b1);
    check("post_rst_y",     int'(y_a),  0);
    check("post_rst_shift", int'(sh_a), 4'b0001);
    run_stream(1'b1, 16'b0110, 4, ys);
    check("rstpat_b_y", int'(y_b), 1);
    check("rstpat_a_y", int'(y_a), 0);
    run_stream(1'b1, 16'b0000, 4, ys);
    check("rstpat_a_zero_y", int'(y_a), 1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       rp = 4'b1011;
        1:       rp = 4'b0000;
        2:       rp = 4'b1111;
        default: rp = 4'($urandom_range(0, 15));
      endcase
      if (r < 1)
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, rp, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      else if (r < 4)
        cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), rp, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r < 7)
        cyc(1'b1, 1'b0, 1'b1, rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      else
        cyc(1'b1, 1'b0, 1'b0, rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 80),
            1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
